// File: rtl/snake_pkg.sv
// Shared constants and types for the snake display pipeline.
// Positions use p = 10*R + C with R in 1..8, C in 2..9.
package snake_pkg;
   localparam int SEG_W      = 8;
   localparam int SEG_N      = 9;
   localparam int GRID_ROWS  = 8;
   localparam int GRID_COLS  = 8;
   localparam int POS_MIN    = 12;
   localparam int POS_MAX    = 89;
   localparam int ROW_STRIDE = 10;
   localparam int COL_OFFSET = 2;
   // Nine body segments plus the apple.
   localparam int SRC_N      = SEG_N + 1;

   typedef enum logic [1:0] {
      SNAP = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } scan_state_e;
endpackage

// File: rtl/snake_pos_decode.sv
// Maps a packed position onto one matrix row without a divider:
// a hit means the position lies in row_idx, col_onehot marks its column.
module snake_pos_decode
   import snake_pkg::*;
(
   input  logic [SEG_W-1:0]     p,
   input  logic [2:0]           row_idx,
   output logic                 hit,
   output logic [GRID_COLS-1:0] col_onehot
);
   logic [SEG_W-1:0] base;
   logic [SEG_W-1:0] offs;
   logic             in_range;

   always_comb begin
      base     = SEG_W'(ROW_STRIDE) * (SEG_W'(row_idx) + SEG_W'(1));
      // Positions left of the row wrap to a large value and never look like a column.
      offs     = p - base - SEG_W'(COL_OFFSET);
      in_range = (p >= SEG_W'(POS_MIN)) && (p <= SEG_W'(POS_MAX));
      hit      = in_range && (offs < SEG_W'(GRID_COLS));
      col_onehot = hit ? (GRID_COLS'(1) << offs[2:0]) : '0;
   end
endmodule

// File: rtl/snake_matrix_scan.sv
// Row-multiplexed 8x8 LED scanner: composes one row per period from a
// per-frame snapshot of the snake and apple, and shows it the period after.
module snake_matrix_scan
   import snake_pkg::*;
#(
   parameter int ROW_DIV      = 1000,
   parameter int BLINK_FRAMES = 32,
   parameter bit APPLE_BLINK  = 1'b1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SEG_N*SEG_W-1:0] snake,
   input  logic [SEG_W-1:0]       apple,
   output logic [GRID_ROWS-1:0]   row_n,
   output logic [GRID_COLS-1:0]   col,
   output logic                   frame_start,
   output scan_state_e            state_dbg
);
   localparam int DIV_W = $clog2(ROW_DIV);
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ROW_DIV - 1);
   localparam logic [DIV_W-1:0] ACC_LAST = DIV_W'(SRC_N);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   scan_state_e              state, state_nxt;
   logic [DIV_W-1:0]         div_cnt;
   logic [DIV_W-1:0]         src_k;
   logic [2:0]               row_idx;
   logic [FRM_W-1:0]         frame_cnt;
   logic                     blink_on;
   logic [GRID_COLS-1:0]     acc;
   logic [SEG_N*SEG_W-1:0]   snake_sh;
   logic [SEG_W-1:0]         apple_sh;
   logic [SEG_W-1:0]         src_pos;
   logic                     src_hit;
   logic [GRID_COLS-1:0]     src_col;
   logic                     snap_en, acc_clr, acc_en, row_end;

   always_ff @(posedge clk) begin
      if (!rst) state <= SNAP;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SNAP:    state_nxt = ACC;
         ACC:     if (div_cnt == ACC_LAST) state_nxt = HOLD;
         HOLD:    if (div_cnt == DIV_LAST) state_nxt = SNAP;
         default: state_nxt = SNAP;
      endcase
   end

   always_comb begin
      snap_en     = (state == SNAP) && (row_idx == 3'd0);
      acc_clr     = (state == SNAP);
      acc_en      = (state == ACC);
      row_end     = (state == HOLD) && (div_cnt == DIV_LAST);
      frame_start = snap_en && rst;
      state_dbg   = state;
   end

   // Source k = div_cnt-1: segments 0..8, then the apple gated by blink.
   always_comb begin
      src_k   = div_cnt - DIV_W'(1);
      src_pos = '0;
      for (int k = 0; k < SEG_N; k++) begin
         if (src_k == DIV_W'(k)) src_pos = snake_sh[k*SEG_W +: SEG_W];
      end
      if ((src_k == DIV_W'(SEG_N)) && (blink_on || !APPLE_BLINK)) src_pos = apple_sh;
   end

   snake_pos_decode u_dec (
      .p          (src_pos),
      .row_idx    (row_idx),
      .hit        (src_hit),
      .col_onehot (src_col)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt   <= '0;
         row_idx   <= 3'd0;
         frame_cnt <= '0;
         blink_on  <= 1'b1;
         acc       <= '0;
         snake_sh  <= '0;
         apple_sh  <= '0;
         row_n     <= '1;
         col       <= '0;
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         if (snap_en) begin
            snake_sh <= snake;
            apple_sh <= apple;
         end
         if (acc_clr)     acc <= '0;
         else if (acc_en) acc <= acc | (src_hit ? src_col : '0);
         // Row select and columns switch on the same edge, so no glitch cycle.
         if (row_end) begin
            row_n   <= ~(GRID_ROWS'(1) << row_idx);
            col     <= acc;
            row_idx <= row_idx + 3'd1;
            if (row_idx == 3'(GRID_ROWS - 1)) begin
               if (frame_cnt == FRM_LAST) begin
                  frame_cnt <= '0;
                  blink_on  <= ~blink_on;
               end else begin
                  frame_cnt <= frame_cnt + FRM_W'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_snake_matrix_scan.sv
// Scoreboard bench: a blinking and a steady-apple scanner share inputs;
// whole frames of expected rows are queued at each snapshot and popped per period.
module tb_snake_matrix_scan;
   localparam int ROW_DIV      = 12;
   localparam int BLINK_FRAMES = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [71:0] snake = '0;
   logic [7:0]  apple = '0;
   logic [7:0]  row_n, col, row_n_s, col_s;
   logic        frame_start, frame_start_s;
   snake_pkg::scan_state_e state_dbg, state_dbg_s;

   // {row_n, col of blinking instance, col of steady instance}
   logic [23:0] exp_q[$];
   logic [23:0] last_exp;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          m_frame_cnt = 0;
   bit          m_blink = 1'b1;

   always #5 clk = ~clk;

   snake_matrix_scan #(.ROW_DIV(ROW_DIV), .BLINK_FRAMES(BLINK_FRAMES), .APPLE_BLINK(1'b1)) dut (
      .clk(clk), .rst(rst), .snake(snake), .apple(apple),
      .row_n(row_n), .col(col), .frame_start(frame_start), .state_dbg(state_dbg)
   );

   snake_matrix_scan #(.ROW_DIV(ROW_DIV), .BLINK_FRAMES(BLINK_FRAMES), .APPLE_BLINK(1'b0)) dut_steady (
      .clk(clk), .rst(rst), .snake(snake), .apple(apple),
      .row_n(row_n_s), .col(col_s), .frame_start(frame_start_s), .state_dbg(state_dbg_s)
   );

   function automatic logic [7:0] model_row(int row, logic [71:0] s, logic [7:0] a, bit apple_en);
      logic [7:0] m;
      int p;
      m = '0;
      for (int k = 0; k < 10; k++) begin
         if (k < 9) p = int'(s[k*8 +: 8]);
         else       p = apple_en ? int'(a) : 0;
         if (p >= 12 && p <= 89 && (p % 10) >= 2 && (p / 10) - 1 == row) m[(p % 10) - 2] = 1'b1;
      end
      return m;
   endfunction

   task automatic push_frame();
      for (int r = 0; r < 8; r++)
         exp_q.push_back({~(8'h01 << r), model_row(r, snake, apple, m_blink), model_row(r, snake, apple, 1'b1)});
      if (m_frame_cnt == BLINK_FRAMES - 1) begin
         m_frame_cnt = 0;
         m_blink = !m_blink;
      end else begin
         m_frame_cnt++;
      end
   endtask

   // One clock cycle; entered and left on a falling edge.
   task automatic step();
      int ph, per, row;
      logic exp_fs;
      #1;
      ph  = cyc % ROW_DIV;
      per = cyc / ROW_DIV;
      row = per % 8;
      exp_fs = (ph == 0) && (row == 0);
      if (ph == 0 || ph == ROW_DIV - 1) begin
         n_checks++;
         if (frame_start !== exp_fs || frame_start_s !== exp_fs) begin
            n_fail++;
            $display("FAIL frame_start cyc=%0d got %b/%b expected %b", cyc, frame_start, frame_start_s, exp_fs);
         end
      end
      if (ph == 0) begin
         if (row == 0) push_frame();
         if (per > 0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL queue_empty cyc=%0d got no expected row, required one", cyc);
            end else begin
               last_exp = exp_q.pop_front();
            end
         end
      end
      if (ph == 0 || ph == ROW_DIV - 1) begin
         n_checks++;
         if ({row_n, col, col_s} !== last_exp || row_n_s !== last_exp[23:16]) begin
            n_fail++;
            $display("FAIL row_out cyc=%0d got row_n=%h/%h col=%h/%h expected row_n=%h col=%h/%h",
                     cyc, row_n, row_n_s, col, col_s, last_exp[23:16], last_exp[15:8], last_exp[7:0]);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_periods(int n);
      for (int i = 0; i < n * ROW_DIV; i++) step();
   endtask

   task automatic run_to_row(int r);
      while (cyc % ROW_DIV != 0 || (cyc / ROW_DIV) % 8 != r) step();
   endtask

   task automatic apply_reset(int cycles);
      rst = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (row_n !== 8'hFF || col !== 8'h00 || frame_start !== 1'b0 || row_n_s !== 8'hFF ||
             col_s !== 8'h00 || state_dbg !== snake_pkg::SNAP) begin
            n_fail++;
            $display("FAIL reset_state got row_n=%h col=%h fs=%b state=%0d expected FF 00 0 SNAP",
                     row_n, col, frame_start, state_dbg);
         end
      end
      rst = 1'b1;
      cyc = 0;
      exp_q.delete();
      last_exp = {8'hFF, 8'h00, 8'h00};
      m_frame_cnt = 0;
      m_blink = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset(3);
   endtask

   task automatic test_single_head();
      snake = '0;
      snake[71:64] = 8'd12;
      apple = 8'd0;
      run_periods(17);
   endtask

   task automatic test_overlap();
      run_to_row(0);
      snake = '0;
      snake[71:64] = 8'd45;
      snake[63:56] = 8'd44;
      snake[55:48] = 8'd44;
      apple = 8'd89;
      run_periods(16);
   endtask

   task automatic test_invalid();
      run_to_row(0);
      snake = {8'd20, 8'd31, 8'd95, 8'd5, 40'd0};
      apple = 8'd0;
      run_periods(16);
   endtask

   task automatic test_snapshot();
      run_to_row(0);
      snake = '0;
      snake[71:64] = 8'd12;
      apple = 8'd0;
      run_to_row(3);
      snake[71:64] = 8'd23;
      run_periods(14);
   endtask

   task automatic test_blink();
      run_to_row(0);
      snake = '0;
      apple = 8'd89;
      run_periods(40);
   endtask

   task automatic test_random();
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 9; k++) snake[k*8 +: 8] = 8'($urandom_range(0, 99));
         apple = 8'($urandom_range(0, 99));
         run_periods($urandom_range(3, 10));
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      run_to_row(0);
      snake = '0;
      apple = 8'd89;
      guard = 0;
      while (m_blink && guard < 8) begin
         run_periods(8);
         guard++;
      end
      run_periods(4);
      for (int i = 0; i < 5; i++) step();
      apply_reset(1);
      run_periods(17);
   endtask

   initial begin
      test_reset();
      test_single_head();
      test_overlap();
      test_invalid();
      test_snapshot();
      test_blink();
      test_random();
      test_reset_mid();
      run_periods(9);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
